// File: rtl/alu_frame_loader.sv
// Front end of the ALU. It assembles a 3-byte command frame (A, B, opcode) from a byte stream.
// It then registers the ALU result and offers it as one byte on a valid/ready output.
`timescale 1ns/1ps
module alu_frame_loader #(
    parameter int NB_OPERANDO    = 8,
    parameter int NB_OPCODE      = 6,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int NB_TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NB_OPERANDO-1:0] rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [NB_OPERANDO-1:0] dato_a,
    output logic [NB_OPERANDO-1:0] dato_b,
    output logic [NB_OPCODE-1:0]   opcode,
    input  logic [NB_OPERANDO-1:0] alu_out,
    output logic [NB_OPERANDO-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   err_opcode,
    output logic                   err_timeout
);
    typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SEND} state_t;

    localparam logic [NB_OPCODE-1:0]  OP_ADD = NB_OPCODE'(6'h20);
    localparam logic [NB_OPCODE-1:0]  OP_SUB = NB_OPCODE'(6'h22);
    localparam logic [NB_OPCODE-1:0]  OP_AND = NB_OPCODE'(6'h24);
    localparam logic [NB_OPCODE-1:0]  OP_OR  = NB_OPCODE'(6'h25);
    localparam logic [NB_OPCODE-1:0]  OP_XOR = NB_OPCODE'(6'h26);
    localparam logic [NB_OPCODE-1:0]  OP_NOR = NB_OPCODE'(6'h27);
    localparam logic [NB_OPCODE-1:0]  OP_SRA = NB_OPCODE'(6'h03);
    localparam logic [NB_OPCODE-1:0]  OP_SRL = NB_OPCODE'(6'h02);
    localparam bit                    TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [NB_OPERANDO-1:0]   dato_a_q, dato_a_d;
    logic [NB_OPERANDO-1:0]   dato_b_q, dato_b_d;
    logic [NB_OPCODE-1:0]     opcode_q, opcode_d;
    logic [NB_OPERANDO-1:0]   tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d;
    logic                     err_opcode_q, err_opcode_d;
    logic                     err_timeout_q, err_timeout_d;
    logic [NB_TIMEOUT-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic rx_xfer, tx_xfer, op_legal, in_frame, timeout_hit;

    assign rx_xfer     = rx_valid & rx_ready;
    assign tx_xfer     = tx_valid_q & tx_ready;
    assign in_frame    = (state_q == S_B) || (state_q == S_OP);
    // A byte landing on the expiry cycle wins over the timeout.
    assign timeout_hit = TMO_EN && in_frame && !rx_xfer && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        op_legal = 1'b0;
        if (rx_data[NB_OPERANDO-1:NB_OPCODE] == '0) begin
            case (rx_data[NB_OPCODE-1:0])
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_legal = 1'b1;
                default:                        op_legal = 1'b0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:     if (rx_xfer) state_d = S_B;
            S_B: begin
                if (rx_xfer)          state_d = S_OP;
                else if (timeout_hit) state_d = S_A;
            end
            S_OP: begin
                if (rx_xfer)          state_d = op_legal ? S_EXEC : S_A;
                else if (timeout_hit) state_d = S_A;
            end
            S_EXEC:  state_d = S_SEND;
            S_SEND:  if (tx_xfer) state_d = S_A;
            default: state_d = S_A;
        endcase
    end

    // Output logic
    always_comb begin
        rx_ready = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);
    end

    always_comb begin
        dato_a_d      = dato_a_q;
        dato_b_d      = dato_b_q;
        opcode_d      = opcode_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        err_opcode_d  = 1'b0;
        err_timeout_d = timeout_hit;
        tmo_cnt_d     = (rx_xfer || !in_frame || timeout_hit) ? '0 : tmo_cnt_q + NB_TIMEOUT'(1);
        case (state_q)
            S_A:  if (rx_xfer) dato_a_d = rx_data;
            S_B:  if (rx_xfer) dato_b_d = rx_data;
            S_OP: begin
                if (rx_xfer) begin
                    if (op_legal) opcode_d     = rx_data[NB_OPCODE-1:0];
                    else          err_opcode_d = 1'b1;
                end
            end
            // ALU inputs have been stable since the opcode edge, so alu_out is settled here.
            S_EXEC: begin
                tx_data_d  = alu_out;
                tx_valid_d = 1'b1;
            end
            S_SEND:  if (tx_xfer) tx_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dato_a_q      <= '0;
            dato_b_q      <= '0;
            opcode_q      <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            dato_a_q      <= dato_a_d;
            dato_b_q      <= dato_b_d;
            opcode_q      <= opcode_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            err_opcode_q  <= err_opcode_d;
            err_timeout_q <= err_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign dato_a      = dato_a_q;
    assign dato_b      = dato_b_q;
    assign opcode      = opcode_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign err_opcode  = err_opcode_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_alu_frame_loader.sv
// Directed plus randomized frames for alu_frame_loader; the bench supplies the ALU
// and predicts every result, error pulse and handshake from the frame rules.
`timescale 1ns/1ps
module tb_alu_frame_loader;
    localparam int NB = 8;
    localparam int NO = 6;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [NB-1:0] dato_a, dato_b, alu_out, tx_data;
    logic [NO-1:0] opcode;
    logic          tx_valid, tx_ready, err_opcode, err_timeout;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [NB-1:0] exp_a, exp_b, exp_tx;
    logic [NO-1:0] exp_op;
    bit            ready_seen;

    alu_frame_loader #(
        .NB_OPERANDO(NB), .NB_OPCODE(NO), .TIMEOUT_CYCLES(TO), .NB_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .dato_a(dato_a), .dato_b(dato_b), .opcode(opcode),
        .alu_out(alu_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_opcode(err_opcode), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [NB-1:0] alu_fn(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                              input logic [NO-1:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return NB'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_out = alu_fn(dato_a, dato_b, opcode);

    function automatic bit is_legal(input logic [NB-1:0] v);
        return (v[7:6] == 2'b00) &&
               (v[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [NB-1:0] d);
        @(negedge clk);
        rx_valid   = v;
        rx_data    = d;
        ready_seen = rx_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [NB-1:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) step(1'b0, '0);
        for (int i = 0; i < 40 && !ok; i++) begin
            step(1'b1, d);
            ok = ready_seen;
        end
        if (!ok) chk("rx_accept_bound", 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dato_a"}, dato_a, 0);
        chk({tag, "_dato_b"}, dato_b, 0);
        chk({tag, "_opcode"}, opcode, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_err_op"}, err_opcode, 0);
        chk({tag, "_err_tmo"}, err_timeout, 0);
        chk({tag, "_rx_ready"}, rx_ready, 1);
        exp_a  = '0;
        exp_b  = '0;
        exp_op = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame: A, B, opcode with idle gaps; tx held off for 'hold' cycles.
    task automatic run_frame(input logic [NB-1:0] a, input logic [NB-1:0] b,
                             input logic [NB-1:0] op, input int gap, input int hold);
        send_byte(a, gap);
        exp_a = a;
        chk("dato_a", dato_a, exp_a);
        send_byte(b, gap);
        exp_b = b;
        chk("dato_b", dato_b, exp_b);
        send_byte(op, gap);
        if (is_legal(op)) begin
            exp_op = op[5:0];
            exp_tx = alu_fn(exp_a, exp_b, exp_op);
            chk("opcode", opcode, exp_op);
            chk("err_op_legal", err_opcode, 0);
            chk("tx_valid_exec", tx_valid, 0);
            chk("rx_ready_exec", rx_ready, 0);
            tx_ready = (hold == 0);
            step(1'b0, '0);
            chk("tx_valid_up", tx_valid, 1);
            chk("tx_data", tx_data, exp_tx);
            chk("rx_ready_send", rx_ready, 0);
            for (int i = 0; i < hold; i++) begin
                step(1'b1, NB'($urandom));
                chk("hold_tx_valid", tx_valid, 1);
                chk("hold_tx_data", tx_data, exp_tx);
                chk("hold_rx_ready", rx_ready, 0);
                chk("hold_dato_a", dato_a, exp_a);
                chk("hold_dato_b", dato_b, exp_b);
            end
            tx_ready = 1'b1;
            step(1'b0, '0);
            chk("tx_valid_done", tx_valid, 0);
            chk("rx_ready_next", rx_ready, 1);
        end else begin
            chk("err_op_pulse", err_opcode, 1);
            chk("opcode_kept", opcode, exp_op);
            chk("tx_valid_illegal", tx_valid, 0);
            step(1'b0, '0);
            chk("err_op_clear", err_opcode, 0);
            chk("rx_ready_after_err", rx_ready, 1);
            chk("tx_valid_after_err", tx_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] legal_ops [8];
        legal_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ADD
        run_frame(8'h05, 8'h03, 8'h20, 0, 0);
        chk("t1_result", tx_data, 8'h08);

        // SUB then NOR back-to-back
        run_frame(8'h03, 8'h05, 8'h22, 0, 0);
        chk("t2_sub", tx_data, 8'hFE);
        run_frame(8'hF0, 8'h0F, 8'h27, 0, 0);
        chk("t2_nor", tx_data, 8'h00);

        // Illegal opcodes, then OR
        run_frame(8'h01, 8'h02, 8'h21, 0, 0);
        run_frame(8'h01, 8'h02, 8'hA0, 0, 0);
        run_frame(8'h01, 8'h02, 8'h25, 0, 0);
        chk("t3_or", tx_data, 8'h03);

        // Timeout in S_B after TO idle cycles
        send_byte(8'h11, 0);
        exp_a = 8'h11;
        for (int i = 0; i < TO - 1; i++) begin
            step(1'b0, '0);
            chk("tmo_quiet", err_timeout, 0);
        end
        step(1'b0, '0);
        chk("tmo_pulse", err_timeout, 1);
        chk("tmo_dato_a", dato_a, exp_a);
        chk("tmo_dato_b", dato_b, exp_b);
        chk("tmo_opcode", opcode, exp_op);
        step(1'b0, '0);
        chk("tmo_clear", err_timeout, 0);
        run_frame(8'h04, 8'h01, 8'h02, 0, 0);
        chk("t4_srl", tx_data, 8'h02);

        // Byte on the expiry cycle is taken; then a timeout from S_OP
        send_byte(8'h33, 0);
        exp_a = 8'h33;
        repeat (TO - 1) step(1'b0, '0);
        send_byte(8'h44, 0);
        exp_b = 8'h44;
        chk("expiry_no_tmo", err_timeout, 0);
        chk("expiry_dato_b", dato_b, exp_b);
        repeat (TO - 1) step(1'b0, '0);
        chk("op_tmo_quiet", err_timeout, 0);
        step(1'b0, '0);
        chk("op_tmo_pulse", err_timeout, 1);
        chk("op_tmo_opcode", opcode, exp_op);
        run_frame(8'h09, 8'h04, 8'h24, 0, 0);

        // Backpressure on tx with SRA
        run_frame(8'h80, 8'h01, 8'h03, 0, 10);
        chk("t5_sra", tx_data, 8'hC0);

        // Reset mid-frame
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        run_frame(8'h07, 8'h02, 8'h26, 0, 0);
        chk("t6_xor", tx_data, 8'h05);

        // Reset while a result is pending
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h20, 0);
        tx_ready = 1'b0;
        step(1'b0, '0);
        chk("pend_tx_valid", tx_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("pend_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        run_frame(8'h10, 8'h20, 8'h20, 0, 0);
        chk("t6_add", tx_data, 8'h30);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            logic [NB-1:0] ra, rb, rop;
            ra  = NB'($urandom);
            rb  = NB'($urandom);
            rop = ($urandom_range(0, 3) == 0) ? NB'($urandom) : legal_ops[$urandom_range(0, 7)];
            run_frame(ra, rb, rop, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
